hs_responder: RTL
=================

// Module: hs_responder
// PURPOSE
//  Responder end of the team's IDLE/START/BUSY/DONE 4-phase req/ack handshake.
//  Accepts one request word from an initiator, holds it for a fixed processing latency,
//  then returns a response word with ack. Sits opposite any initiator FSM.
//  Counts completed transactions; flags protocol and (optionally) parity errors.
// PARAMETERS
//  DATA_W   8   request/response word width
//  LAT      4   processing cycles spent in BUSY; legal range 1..255
//  CNT_W    8   width of the completed-transaction counter; wraps modulo 2^CNT_W
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst_b        in   1       reset; asynchronous, active-low
//  req_i        in   1       request level from initiator (4-phase)
//  req_data_i   in   DATA_W  request word; sampled in IDLE when req_i=1
//  req_par_i    in   1       even parity of req_data_i (present only with HS_PARITY_EN)
//  ack_o        out  1       acknowledge level; high throughout DONE
//  rsp_data_o   out  DATA_W  response word; valid while ack_o=1, held after
//  rsp_err_o    out  1       sticky error flag; cleared on next accepted request
//  busy_o       out  1       high in START and BUSY
//  txn_cnt_o    out  CNT_W   number of completed error-free transactions
// BEHAVIOUR
//  Reset: state=IDLE; ack_o, busy_o, rsp_err_o=0; rsp_data_o, txn_cnt_o=0; counter=0.
//  IDLE : req_i=1 -> capture req_data_i into data_q, clear rsp_err_o, go START.
//  START: busy_o=1; load lat_cnt=LAT-1; go BUSY next edge.
//  BUSY : lat_cnt!=0 -> decrement; lat_cnt==0 -> go DONE, register ack_o=1 and
//         rsp_data_o = data_q + txn_cnt_o (DATA_W-bit sum, carry discarded).
//  DONE : hold ack_o=1 and rsp_data_o until req_i=0; then ack_o=0,
//         txn_cnt_o+=1 (wraps), go IDLE.
//  Latency: req_i sampled high at edge N -> ack_o high after edge N+LAT+1.
//  Protocol violation: req_i=0 in START or BUSY -> abort; rsp_err_o=1, no ack,
//    txn_cnt_o unchanged, go IDLE.
//  Back-to-back: req_i re-asserted the cycle after ack_o falls is accepted from IDLE.
//  req_data_i changes after capture are ignored.
//  Reset mid-operation: immediate return to reset values; no ack for in-flight request;
//    a req_i still high after reset release is accepted as a new request.
//  txn_cnt_o at 2^CNT_W-1 wraps to 0 on next completion.
// CONFIGURATION
//  HS_PARITY_EN defined: req_par_i port exists; in IDLE on capture, if
//    ^req_data_i != req_par_i the handshake still completes normally but in DONE
//    rsp_data_o=0, rsp_err_o=1, and txn_cnt_o is not incremented on req_i fall.
//  HS_PARITY_EN undefined: req_par_i port absent; no parity check; rsp_err_o
//    set only by protocol violation.
// STRUCTURE
//  Package hs_pkg: hs_state_e (IDLE=2'b00, START=2'b01, BUSY=2'b10, DONE=2'b11),
//    shared with the initiator; HS_LAT_MAX=255 constant.
//  Sub-module hs_down_counter: loadable 8-bit down counter with zero flag
//    (load, dec, cnt, zero); instantiated once for lat_cnt.
//  Single always_ff (async rst_b) for state/regs; single always_comb for next state.
// TESTING
//  1 LAT=4, req_i=1 with data 8'h10 at edge 0 -> ack_o=1 after edge 5,
//    rsp_data_o=8'h10, busy_o high edges 1-4; drop req -> ack_o=0, txn_cnt_o=1.
//  2 Second txn with data 8'h10 -> rsp_data_o=8'h11; 256 txns from reset ->
//    txn_cnt_o wraps to 0.
//  3 req_i dropped during BUSY -> rsp_err_o=1, ack_o stays 0, txn_cnt_o unchanged;
//    next req clears rsp_err_o.
//  4 rst_b asserted in BUSY -> all outputs 0 immediately; req_i held high through
//    release -> new txn completes with ack after LAT+1 edges.
//  5 HS_PARITY_EN, data 8'h01, req_par_i=0 -> ack_o=1, rsp_data_o=0, rsp_err_o=1,
//    txn_cnt_o unchanged; correct parity -> normal response.
//  6 LAT=1 back-to-back requests, req re-asserted cycle after ack fall -> each
//    acked after 2 edges, no lost transactions.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for the IDLE/START/BUSY/DONE 4-phase req/ack handshake.
// The state encoding is also used by the initiator side.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        BUSY  = 2'b10,
        DONE  = 2'b11
    } hs_state_e;

    localparam int HS_LAT_MAX = 255;
    localparam int HS_CNT_W   = 8;

endpackage

// File: rtl/hs_down_counter.sv
// Loadable 8-bit down counter with zero flag; holds at zero rather than wrapping.
module hs_down_counter (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
    output logic [7:0] cnt,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/hs_responder.sv
// Responder end of the 4-phase req/ack handshake: capture, wait LAT cycles, ack with data.
// Optional parity check of the request word is enabled by defining HS_PARITY_EN.
module hs_responder
    import hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LAT    = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_i,
    input  logic [DATA_W-1:0] req_data_i,
`ifdef HS_PARITY_EN
    input  logic              req_par_i,
`endif
    output logic              ack_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  txn_cnt_o,
    output hs_state_e         state_o
);

    // LAT must lie in 1..HS_LAT_MAX so LAT-1 fits the 8-bit latency counter.
    localparam logic [7:0] LAT_LOAD = 8'(LAT - 1);

    hs_state_e         state_q;
    hs_state_e         state_d;
    logic [DATA_W-1:0] data_q;
    logic              par_err_q;
    logic              par_bad;
    logic [DATA_W-1:0] rsp_sum;

    logic              capture;
    logic              abort;
    logic              finish;
    logic              complete;
    logic              cnt_load;
    logic              cnt_dec;
    logic [7:0]        lat_cnt;
    logic              lat_zero;

`ifdef HS_PARITY_EN
    assign par_bad = (^req_data_i) != req_par_i;
`else
    assign par_bad = 1'b0;
`endif

    assign rsp_sum = data_q + DATA_W'(txn_cnt_o);
    assign busy_o  = (state_q == START) || (state_q == BUSY);
    assign state_o = state_q;

    hs_down_counter u_lat_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (LAT_LOAD),
        .cnt      (lat_cnt),
        .zero     (lat_zero)
    );

    // A dropped req during START/BUSY takes priority over finishing the wait.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        abort    = 1'b0;
        finish   = 1'b0;
        complete = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    capture = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (!req_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!req_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (lat_zero) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_dec = (lat_cnt != 8'd0);
                end
            end
            DONE: begin
                if (!req_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            ack_o      <= 1'b0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
            txn_cnt_o  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                data_q    <= req_data_i;
                par_err_q <= par_bad;
                rsp_err_o <= 1'b0;
            end
            if (abort) begin
                rsp_err_o <= 1'b1;
            end
            // A parity-failed request still completes, but with a zeroed, flagged response.
            if (finish) begin
                ack_o <= 1'b1;
                if (par_err_q) begin
                    rsp_data_o <= '0;
                    rsp_err_o  <= 1'b1;
                end else begin
                    rsp_data_o <= rsp_sum;
                end
            end
            if (complete) begin
                ack_o <= 1'b0;
                if (!par_err_q) begin
                    txn_cnt_o <= txn_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule
